// File: rtl/clock_rst_sink_pkg.sv
// Shared types and defaults for the bench clock/reset sink and its source.
package clock_rst_sink_pkg;

  typedef enum logic [2:0] {
    CRS_RESET = 3'd0,
    CRS_SYNC  = 3'd1,
    CRS_HOLD  = 3'd2,
    CRS_RUN   = 3'd3,
    CRS_DONE  = 3'd4
  } crs_state_e;

  localparam int unsigned CRS_CNT_W       = 64;
  localparam int unsigned CRS_SYNC_STAGES = 2;

endpackage

// File: rtl/clock_rst_sink_if.sv
// Heartbeat input and status outputs of the clock/reset sink.
interface clock_rst_sink_if
  import clock_rst_sink_pkg::*;
#(
  parameter int unsigned CNT_W = CRS_CNT_W
);

  // hb is a one-cycle pulse sampled on posedge clock; there is no back-pressure.
  // ready is high exactly while the sink is in RUN and rst_out_x is released.
  logic             hb;
  logic             rst_out_x;
  logic             ready;
  logic             done;
  logic [CNT_W-1:0] ccnt;
  logic             wdog_err;
  crs_state_e       state;

  modport master (
    output hb,
    input  rst_out_x, ready, done, ccnt, wdog_err, state
  );

  modport slave (
    input  hb,
    output rst_out_x, ready, done, ccnt, wdog_err, state
  );

endinterface

// File: rtl/clock_rst_sink_rst_sync_chain.sv
// Async-assert / sync-release shift chain; ones shift in while rst_x is high.
module rst_sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clock,
  input  logic rst_x,
  output logic rel_sync,
  output logic rel_pre
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clock or negedge rst_x) begin
    if (!rst_x) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], 1'b1};
    end
  end

  // rel_pre is the stage that becomes rel_sync on the next edge.
  assign rel_sync = chain[STAGES-1];
  assign rel_pre  = chain[STAGES-2];

endmodule

// File: rtl/clock_rst_sink.sv
// Reset release sequencer, run-cycle counter and heartbeat watchdog.
module clock_rst_sink
  import clock_rst_sink_pkg::*;
#(
  parameter int unsigned      SYNC_STAGES = CRS_SYNC_STAGES,
  parameter int unsigned      RST_HOLD    = 5,
  parameter longint unsigned  PERIOD_CNT  = 0,
  parameter int unsigned      CNT_W       = CRS_CNT_W,
  parameter int unsigned      WDOG_CYC    = 16
) (
  input  logic           clock,
  input  logic           rst_x,
  clock_rst_sink_if.slave bus
);

  localparam int unsigned HOLD_W = (RST_HOLD > 0) ? $clog2(RST_HOLD + 1) : 1;
  localparam int unsigned GAP_W  = (WDOG_CYC > 0) ? $clog2(WDOG_CYC + 1) : 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((RST_HOLD > 0) ? RST_HOLD - 1 : 0);
  localparam logic [GAP_W-1:0]  GAP_LIMIT = GAP_W'(WDOG_CYC);
  localparam logic [CNT_W-1:0]  PERIOD_V  = CNT_W'(PERIOD_CNT);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("clock_rst_sink: SYNC_STAGES must be at least 2");
  end
  if ((CNT_W < 64) && (PERIOD_CNT >= (64'd1 << CNT_W))) begin : g_bad_period
    $error("clock_rst_sink: PERIOD_CNT does not fit in CNT_W bits");
  end

  logic rel_sync;
  logic rel_pre;

  rst_sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clock    (clock),
    .rst_x    (rst_x),
    .rel_sync (rel_sync),
    .rel_pre  (rel_pre)
  );

  crs_state_e        state_q;
  logic [HOLD_W-1:0] hold_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [CNT_W-1:0]  ccnt_q;
  logic              rst_out_q;
  logic              ready_q;
  logic              done_q;
  logic              wdog_q;

  logic [CNT_W-1:0]  ccnt_inc;
  logic [GAP_W-1:0]  gap_inc;

  assign ccnt_inc = ccnt_q + CNT_W'(1);
  assign gap_inc  = gap_cnt + GAP_W'(1);

  always_ff @(posedge clock or negedge rst_x) begin
    if (!rst_x) begin
      state_q   <= CRS_RESET;
      hold_cnt  <= '0;
      gap_cnt   <= '0;
      ccnt_q    <= '0;
      rst_out_q <= 1'b0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      wdog_q    <= 1'b0;
    end else begin
      case (state_q)
        CRS_RESET: state_q <= CRS_SYNC;

        // rel_pre high here means the chain's last stage sets on this very edge.
        CRS_SYNC: begin
          if (rel_pre) begin
            if (RST_HOLD == 0) begin
              state_q   <= CRS_RUN;
              rst_out_q <= 1'b1;
              ready_q   <= 1'b1;
              gap_cnt   <= '0;
            end else begin
              state_q  <= CRS_HOLD;
              hold_cnt <= '0;
            end
          end
        end

        CRS_HOLD: begin
          if (rel_sync && (hold_cnt == HOLD_LAST)) begin
            state_q   <= CRS_RUN;
            rst_out_q <= 1'b1;
            ready_q   <= 1'b1;
            gap_cnt   <= '0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        CRS_RUN: begin
          if (ccnt_q != CNT_MAX) begin
            ccnt_q <= ccnt_inc;
          end
          if ((PERIOD_CNT != 0) && (ccnt_inc == PERIOD_V)) begin
            state_q <= CRS_DONE;
            done_q  <= 1'b1;
            ready_q <= 1'b0;
          end
          // A heartbeat on the expiry cycle clears the gap before it can trip.
          if (WDOG_CYC != 0) begin
            if (bus.hb) begin
              gap_cnt <= '0;
            end else if (gap_cnt != GAP_LIMIT) begin
              gap_cnt <= gap_inc;
              if (gap_inc == GAP_LIMIT) begin
                wdog_q <= 1'b1;
              end
            end
          end
        end

        CRS_DONE: state_q <= CRS_DONE;

        default: state_q <= CRS_RESET;
      endcase
    end
  end

  assign bus.rst_out_x = rst_out_q;
  assign bus.ready     = ready_q;
  assign bus.done      = done_q;
  assign bus.ccnt      = ccnt_q;
  assign bus.wdog_err  = wdog_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_clock_rst_sink.sv
// Directed bench: four sink configurations share one clock and run side by side.
module tb_clock_rst_sink;
  import clock_rst_sink_pkg::*;

  logic clock;
  logic rst0, rst2, rst3, rst6;
  int   tests;
  int   fails;

  // Clock and reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  clock_rst_sink_if #(.CNT_W(64)) if0 ();
  clock_rst_sink_if #(.CNT_W(64)) if2 ();
  clock_rst_sink_if #(.CNT_W(64)) if3 ();
  clock_rst_sink_if #(.CNT_W(4))  if6 ();

  clock_rst_sink u0 (
    .clock (clock), .rst_x (rst0), .bus (if0.slave)
  );

  clock_rst_sink #(
    .SYNC_STAGES (3), .RST_HOLD (0), .WDOG_CYC (0)
  ) u2 (
    .clock (clock), .rst_x (rst2), .bus (if2.slave)
  );

  clock_rst_sink #(
    .PERIOD_CNT (20), .WDOG_CYC (0)
  ) u3 (
    .clock (clock), .rst_x (rst3), .bus (if3.slave)
  );

  clock_rst_sink #(
    .CNT_W (4), .WDOG_CYC (0)
  ) u6 (
    .clock (clock), .rst_x (rst6), .bus (if6.slave)
  );

  // Scoreboard: each check pops its expectation from exp_q and compares.
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    logic [63:0] want;
    exp_q.push_back(exp);
    want = exp_q.pop_front();
    tests++;
    assert (got === want)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Driver tasks
  int edge_n;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      edge_n++;
    end
  endtask

  task automatic hb_edge();
    if0.hb = 1'b1;
    step(1);
    if0.hb = 1'b0;
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    edge_n = 0;
    rst0 = 1'b0; rst2 = 1'b0; rst3 = 1'b0; rst6 = 1'b0;
    if0.hb = 1'b0; if2.hb = 1'b0; if3.hb = 1'b0; if6.hb = 1'b0;

    // Reset state before any clock edge
    #2;
    check("rst_rst_out", {63'd0, if0.rst_out_x}, 64'd0);
    check("rst_ready",   {63'd0, if0.ready},     64'd0);
    check("rst_done",    {63'd0, if0.done},      64'd0);
    check("rst_ccnt",    if0.ccnt,               64'd0);
    check("rst_wdog",    {63'd0, if0.wdog_err},  64'd0);
    check("rst_state",   64'(if0.state),         64'(CRS_RESET));
    step(2);
    check("rst_held_state", 64'(if0.state), 64'(CRS_RESET));

    rst0 = 1'b1; rst2 = 1'b1; rst3 = 1'b1; rst6 = 1'b1;
    edge_n = 0;

    step(1);  // edge 1
    check("e1_u0_state", 64'(if0.state), 64'(CRS_SYNC));
    check("e1_u2_state", 64'(if2.state), 64'(CRS_SYNC));
    step(1);  // edge 2
    check("e2_u0_state", 64'(if0.state), 64'(CRS_HOLD));
    check("e2_u0_rst_out", {63'd0, if0.rst_out_x}, 64'd0);
    check("e2_u2_state", 64'(if2.state), 64'(CRS_SYNC));
    step(1);  // edge 3: SYNC_STAGES=3, RST_HOLD=0 releases here, HOLD skipped
    check("e3_u2_state",   64'(if2.state), 64'(CRS_RUN));
    check("e3_u2_rst_out", {63'd0, if2.rst_out_x}, 64'd1);
    check("e3_u2_ready",   {63'd0, if2.ready}, 64'd1);
    step(3);  // edge 6
    check("e6_u0_rst_out", {63'd0, if0.rst_out_x}, 64'd0);
    check("e6_u0_ready",   {63'd0, if0.ready}, 64'd0);
    step(1);  // edge 7: defaults release
    check("e7_u0_rst_out", {63'd0, if0.rst_out_x}, 64'd1);
    check("e7_u0_ready",   {63'd0, if0.ready}, 64'd1);
    check("e7_u0_ccnt",    if0.ccnt, 64'd0);
    check("e7_u0_state",   64'(if0.state), 64'(CRS_RUN));
    check("e7_u3_ready",   {63'd0, if3.ready}, 64'd1);
    step(10); // edge 17
    check("e17_u0_ccnt", if0.ccnt, 64'd10);
    check("e17_u0_done", {63'd0, if0.done}, 64'd0);
    check("e17_u2_ccnt", if2.ccnt, 64'd14);
    check("e17_u6_ccnt", 64'(if6.ccnt), 64'd10);
    step(4);  // edge 21
    check("e21_u6_ccnt", 64'(if6.ccnt), 64'd14);
    step(1);  // edge 22: u0 gap now 15
    check("e22_u6_ccnt", 64'(if6.ccnt), 64'd15);
    check("e22_u0_wdog", {63'd0, if0.wdog_err}, 64'd0);
    hb_edge();  // edge 23: hb exactly on the 16th cycle
    check("e23_u0_wdog_hb_wins", {63'd0, if0.wdog_err}, 64'd0);
    step(3);  // edge 26
    check("e26_u3_ccnt",  if3.ccnt, 64'd19);
    check("e26_u3_done",  {63'd0, if3.done}, 64'd0);
    check("e26_u3_ready", {63'd0, if3.ready}, 64'd1);
    step(1);  // edge 27: period reached
    check("e27_u3_done",    {63'd0, if3.done}, 64'd1);
    check("e27_u3_ready",   {63'd0, if3.ready}, 64'd0);
    check("e27_u3_ccnt",    if3.ccnt, 64'd20);
    check("e27_u3_state",   64'(if3.state), 64'(CRS_DONE));
    check("e27_u3_rst_out", {63'd0, if3.rst_out_x}, 64'd1);
    step(11); // edge 38
    hb_edge();  // edge 39
    step(8);  // edge 47
    check("e47_u6_ccnt_sat", 64'(if6.ccnt), 64'd15);
    check("e47_u6_wdog_off", {63'd0, if6.wdog_err}, 64'd0);
    check("e47_u6_state",    64'(if6.state), 64'(CRS_RUN));
    step(7);  // edge 54
    hb_edge();  // edge 55
    check("e55_u0_wdog", {63'd0, if0.wdog_err}, 64'd0);
    step(15); // edge 70: gap 15
    check("e70_u0_wdog", {63'd0, if0.wdog_err}, 64'd0);
    step(1);  // edge 71: gap reaches 16
    check("e71_u0_wdog", {63'd0, if0.wdog_err}, 64'd1);
    hb_edge();  // edge 72
    step(1);  // edge 73
    check("e73_u0_wdog_sticky", {63'd0, if0.wdog_err}, 64'd1);
    step(4);  // edge 77
    check("e77_u3_ccnt_frozen", if3.ccnt, 64'd20);
    check("e77_u3_done",        {63'd0, if3.done}, 64'd1);
    check("e77_u0_ccnt",        if0.ccnt, 64'd70);
    step(30); // edge 107
    check("e107_u0_ccnt", if0.ccnt, 64'd100);
    check("e107_u0_wdog", {63'd0, if0.wdog_err}, 64'd1);

    // 3 ns reset glitch between clock edges
    rst0 = 1'b0;
    #1;
    check("gl_rst_out", {63'd0, if0.rst_out_x}, 64'd0);
    check("gl_ready",   {63'd0, if0.ready}, 64'd0);
    check("gl_ccnt",    if0.ccnt, 64'd0);
    check("gl_wdog",    {63'd0, if0.wdog_err}, 64'd0);
    check("gl_state",   64'(if0.state), 64'(CRS_RESET));
    #2;
    rst0 = 1'b1;
    step(1);
    check("gl_r1_state", 64'(if0.state), 64'(CRS_SYNC));
    step(5);
    check("gl_r6_rst_out", {63'd0, if0.rst_out_x}, 64'd0);
    step(1);
    check("gl_r7_rst_out", {63'd0, if0.rst_out_x}, 64'd1);
    check("gl_r7_ccnt",    if0.ccnt, 64'd0);
    check("gl_r7_wdog",    {63'd0, if0.wdog_err}, 64'd0);
    check("gl_r7_state",   64'(if0.state), 64'(CRS_RUN));

    // Final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
